// File: rtl/nbody_frame_engine.sv
// nbody_frame_engine
//   Once per frame (on frame_start, while idle and not paused) walks all body
//   pairs accumulating Manhattan-distance-banded attraction, then applies one
//   explicit Euler step per body with wrap or bounce at the playfield edges.
//   Every cycle it also renders the bodies as filled diamonds into a
//   registered 6-bit RGB pixel.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   mode[1:0]    in   bit0: 0 wrap / 1 bounce, bit1: pause
//   pix_x,pix_y  in   current pixel coordinate
//   video_active in   display enable
//   rgb[5:0]     out  {R,G,B} 2 bits each, registered (1 clk behind pix_*)
//   busy         out  high during ACCEL and UPDATE
//   step_done    out  one-cycle pulse (DONE state)
//   frame_count  out  completed updates, wraps
//   dbg_state    out  FSM state (IDLE=0, ACCEL=1, UPDATE=2, DONE=3)
//   dbg_pos      out  packed positions, body 0 in LSBs, x below y
//   dbg_vel      out  packed velocities, same packing
//
// Handshake: frame_start is a request with no acknowledge; it is sampled only
// in IDLE with pause clear, and busy/step_done report the resulting update.

module nbody_frame_engine #(
    parameter int N_BODIES = 3,
    parameter int POS_W    = 10,
    parameter int VEL_W    = 6,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int NEAR_D   = 40,
    parameter int FAR_D    = 300,
    parameter int HIT_BOX  = 20,
    parameter int HIT_SUM  = 25,
    parameter logic [N_BODIES*2*POS_W-1:0] INIT_XY =
        {10'd20, 10'd200, 10'd300, 10'd420, 10'd150, 10'd300},
    parameter logic [N_BODIES*2*VEL_W-1:0] INIT_VXY = '0,
    parameter logic [N_BODIES*6-1:0] COLORS = {6'b01_10_11, 6'b10_11_10, 6'b11_10_01}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic [1:0]                    mode,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic                          video_active,
    output logic [5:0]                    rgb,
    output logic                          busy,
    output logic                          step_done,
    output logic [15:0]                   frame_count,
    output logic [1:0]                    dbg_state,
    output logic [N_BODIES*2*POS_W-1:0]   dbg_pos,
    output logic [N_BODIES*2*VEL_W-1:0]   dbg_vel
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEL  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int IDX_W = $clog2(N_BODIES);
    localparam int ACC_W = 5;
    localparam int PW    = POS_W + 2;
    localparam int SW    = VEL_W + ACC_W;
    localparam int RW    = ((POS_W > 10) ? POS_W : 10) + 2;
    localparam logic signed [SW-1:0] VMAX_S = SW'(2**(VEL_W-1) - 1);
    localparam logic signed [SW-1:0] VMIN_S = -VMAX_S;
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_BODIES - 2);
    localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N_BODIES - 1);

    logic [1:0]               r_state;
    logic [IDX_W-1:0]         r_i, r_j, r_b;
    logic [POS_W-1:0]         r_px [N_BODIES];
    logic [POS_W-1:0]         r_py [N_BODIES];
    logic signed [VEL_W-1:0]  r_vx [N_BODIES];
    logic signed [VEL_W-1:0]  r_vy [N_BODIES];
    logic signed [ACC_W-1:0]  r_ax [N_BODIES];
    logic signed [ACC_W-1:0]  r_ay [N_BODIES];
    logic [15:0]              r_frame_count;

    // One Euler step along one axis: returns {v_next, p_next} after
    // saturation and the edge rule selected by bounce.
    function automatic logic [VEL_W+POS_W-1:0] axis_step(
        input logic [POS_W-1:0]        p,
        input logic signed [VEL_W-1:0] v,
        input logic signed [ACC_W-1:0] a,
        input int                      res,
        input logic                    bounce
    );
        logic signed [PW-1:0]    np;
        logic signed [PW-1:0]    rs;
        logic signed [SW-1:0]    vs;
        logic signed [VEL_W-1:0] vn;
        rs = PW'(res);
        np = $signed({2'b00, p}) + PW'(v);
        vs = SW'(v) + SW'(a);
        if (vs > VMAX_S)      vn = VMAX_S[VEL_W-1:0];
        else if (vs < VMIN_S) vn = VMIN_S[VEL_W-1:0];
        else                  vn = vs[VEL_W-1:0];
        if (bounce) begin
            if (np > rs - PW'(1)) begin
                np = rs - PW'(1);
                vn = -vn;
            end else if (np < 0) begin
                np = '0;
                vn = -vn;
            end
        end else begin
            if (np >= rs)    np = np - rs;
            else if (np < 0) np = np + rs;
        end
        return {vn, np[POS_W-1:0]};
    endfunction

    // Pair force for the current (i,j)
    logic signed [PW-1:0]    w_dx, w_dy;
    logic [PW-1:0]           w_adx, w_ady, w_dist;
    logic signed [ACC_W-1:0] w_f, w_cx, w_cy;
    logic [VEL_W+POS_W-1:0]  w_step_x, w_step_y;

    always_comb begin
        w_dx   = $signed({2'b00, r_px[r_j]}) - $signed({2'b00, r_px[r_i]});
        w_dy   = $signed({2'b00, r_py[r_j]}) - $signed({2'b00, r_py[r_i]});
        w_adx  = w_dx[PW-1] ? -w_dx : w_dx;
        w_ady  = w_dy[PW-1] ? -w_dy : w_dy;
        w_dist = w_adx + w_ady;
        if (w_dist < PW'(NEAR_D))     w_f = 5'sd2;
        else if (w_dist < PW'(FAR_D)) w_f = 5'sd1;
        else                          w_f = 5'sd0;
        // s*f with s = sign(pj - pi); zero difference contributes nothing
        w_cx = (w_dx == '0) ? '0 : (w_dx[PW-1] ? -w_f : w_f);
        w_cy = (w_dy == '0) ? '0 : (w_dy[PW-1] ? -w_f : w_f);
        w_step_x = axis_step(r_px[r_b], r_vx[r_b], r_ax[r_b], H_RES, mode[0]);
        w_step_y = axis_step(r_py[r_b], r_vy[r_b], r_ay[r_b], V_RES, mode[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_i           <= '0;
            r_j           <= '0;
            r_b           <= '0;
            r_frame_count <= '0;
            for (int b = 0; b < N_BODIES; b++) begin
                r_px[b] <= INIT_XY[b*2*POS_W +: POS_W];
                r_py[b] <= INIT_XY[b*2*POS_W+POS_W +: POS_W];
                r_vx[b] <= INIT_VXY[b*2*VEL_W +: VEL_W];
                r_vy[b] <= INIT_VXY[b*2*VEL_W+VEL_W +: VEL_W];
                r_ax[b] <= '0;
                r_ay[b] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start && !mode[1]) begin
                        r_state <= S_ACCEL;
                        r_i     <= '0;
                        r_j     <= IDX_W'(1);
                        for (int b = 0; b < N_BODIES; b++) begin
                            r_ax[b] <= '0;
                            r_ay[b] <= '0;
                        end
                    end
                end
                S_ACCEL: begin
                    if (!mode[1]) begin
                        r_ax[r_i] <= r_ax[r_i] + w_cx;
                        r_ay[r_i] <= r_ay[r_i] + w_cy;
                        r_ax[r_j] <= r_ax[r_j] - w_cx;
                        r_ay[r_j] <= r_ay[r_j] - w_cy;
                        if (r_i == LAST_I) begin
                            r_state <= S_UPDATE;
                            r_b     <= '0;
                        end else if (r_j == LAST_B) begin
                            r_i <= r_i + IDX_W'(1);
                            r_j <= r_i + IDX_W'(2);
                        end else begin
                            r_j <= r_j + IDX_W'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    if (!mode[1]) begin
                        r_px[r_b] <= w_step_x[POS_W-1:0];
                        r_vx[r_b] <= w_step_x[VEL_W+POS_W-1:POS_W];
                        r_py[r_b] <= w_step_y[POS_W-1:0];
                        r_vy[r_b] <= w_step_y[VEL_W+POS_W-1:POS_W];
                        if (r_b == LAST_B) r_state <= S_DONE;
                        else               r_b <= r_b + IDX_W'(1);
                    end
                end
                default: begin
                    r_frame_count <= r_frame_count + 16'd1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    // Renderer: descending scan so the lowest-index hit is the final write
    logic [5:0]           w_color;
    logic signed [RW-1:0] w_hdx, w_hdy;
    logic [RW-1:0]        w_hadx, w_hady;

    always_comb begin
        w_color = '0;
        w_hdx   = '0;
        w_hdy   = '0;
        w_hadx  = '0;
        w_hady  = '0;
        for (int b = N_BODIES - 1; b >= 0; b--) begin
            w_hdx  = $signed(RW'(pix_x)) - $signed(RW'(r_px[b]));
            w_hdy  = $signed(RW'(pix_y)) - $signed(RW'(r_py[b]));
            w_hadx = w_hdx[RW-1] ? -w_hdx : w_hdx;
            w_hady = w_hdy[RW-1] ? -w_hdy : w_hdy;
            if (w_hadx < RW'(HIT_BOX) && w_hady < RW'(HIT_BOX) &&
                (w_hadx + w_hady) < RW'(HIT_SUM))
                w_color = COLORS[b*6 +: 6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= video_active ? w_color : 6'd0;
    end

    always_comb begin
        dbg_pos = '0;
        dbg_vel = '0;
        for (int b = 0; b < N_BODIES; b++) begin
            dbg_pos[b*2*POS_W +: POS_W]       = r_px[b];
            dbg_pos[b*2*POS_W+POS_W +: POS_W] = r_py[b];
            dbg_vel[b*2*VEL_W +: VEL_W]       = r_vx[b];
            dbg_vel[b*2*VEL_W+VEL_W +: VEL_W] = r_vy[b];
        end
    end

    assign busy        = (r_state == S_ACCEL) || (r_state == S_UPDATE);
    assign step_done   = (r_state == S_DONE);
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_nbody_frame_engine.sv
module tb_nbody_frame_engine;

  localparam logic [5:0] C0 = 6'b11_10_01;
  localparam logic [5:0] C1 = 6'b10_11_10;
  localparam logic [59:0] INIT3 = {10'd20, 10'd200, 10'd300, 10'd420, 10'd150, 10'd300};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (N=3 defaults)
  logic        rst_n = 1'b0, fs = 1'b0, va = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [9:0]  px = '0, py = '0;
  logic [5:0]  rgb;
  logic        busy, sd;
  logic [15:0] fc;
  logic [1:0]  st;
  logic [59:0] pos;
  logic [35:0] vel;

  nbody_frame_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .mode(mode),
    .pix_x(px), .pix_y(py), .video_active(va),
    .rgb(rgb), .busy(busy), .step_done(sd), .frame_count(fc),
    .dbg_state(st), .dbg_pos(pos), .dbg_vel(vel)
  );

  // wrap / bounce instance (N=2)
  logic        w_rst_n = 1'b0, w_fs = 1'b0;
  logic [1:0]  w_mode = 2'b00;
  logic [5:0]  w_rgb;
  logic        w_busy, w_sd;
  logic [15:0] w_fc;
  logic [1:0]  w_st;
  logic [39:0] w_pos;
  logic [23:0] w_vel;

  nbody_frame_engine #(
    .N_BODIES(2),
    .INIT_XY({10'd400, 10'd10, 10'd100, 10'd638}),
    .INIT_VXY({6'd0, 6'd0, 6'd0, 6'd3}),
    .COLORS({C1, C0})
  ) dut_w (
    .clk(clk), .rst_n(w_rst_n), .frame_start(w_fs), .mode(w_mode),
    .pix_x(10'd0), .pix_y(10'd0), .video_active(1'b0),
    .rgb(w_rgb), .busy(w_busy), .step_done(w_sd), .frame_count(w_fc),
    .dbg_state(w_st), .dbg_pos(w_pos), .dbg_vel(w_vel)
  );

  // render instance (N=2, both bodies at (300,150))
  logic        r_rst_n = 1'b0, r_va = 1'b0;
  logic [9:0]  r_px = '0, r_py = '0;
  logic [5:0]  r_rgb;
  logic        r_busy, r_sd;
  logic [15:0] r_fc;
  logic [1:0]  r_st;
  logic [39:0] r_pos;
  logic [23:0] r_vel;

  nbody_frame_engine #(
    .N_BODIES(2),
    .INIT_XY({10'd150, 10'd300, 10'd150, 10'd300}),
    .INIT_VXY(24'd0),
    .COLORS({C1, C0})
  ) dut_r (
    .clk(clk), .rst_n(r_rst_n), .frame_start(1'b0), .mode(2'b00),
    .pix_x(r_px), .pix_y(r_py), .video_active(r_va),
    .rgb(r_rgb), .busy(r_busy), .step_done(r_sd), .frame_count(r_fc),
    .dbg_state(r_st), .dbg_pos(r_pos), .dbg_vel(r_vel)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_main();
    @(negedge clk) fs = 1'b1;
    @(negedge clk) fs = 1'b0;
  endtask

  task automatic run_frame(input int which, input string name);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (which == 0) fs = 1'b1; else w_fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    w_fs = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if ((which == 0 && sd) || (which == 1 && w_sd)) seen = 1'b1;
      else @(negedge clk);
    end
    chk(name, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [5:0] exp;
  } rvec_t;

  rvec_t tbl[10];

  initial begin
    tbl[0] = '{x: 10'd305, y: 10'd150, v: 1'b1, exp: C0};
    tbl[1] = '{x: 10'd305, y: 10'd150, v: 1'b0, exp: 6'd0};
    tbl[2] = '{x: 10'd319, y: 10'd150, v: 1'b1, exp: C0};
    tbl[3] = '{x: 10'd315, y: 10'd160, v: 1'b1, exp: 6'd0};
    tbl[4] = '{x: 10'd320, y: 10'd150, v: 1'b1, exp: 6'd0};
    tbl[5] = '{x: 10'd300, y: 10'd150, v: 1'b1, exp: C0};
    tbl[6] = '{x: 10'd290, y: 10'd141, v: 1'b1, exp: C0};
    tbl[7] = '{x: 10'd100, y: 10'd100, v: 1'b1, exp: 6'd0};
    tbl[8] = '{x: 10'd281, y: 10'd150, v: 1'b1, exp: C0};
    tbl[9] = '{x: 10'd300, y: 10'd169, v: 1'b1, exp: C0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w_rst_n = 1'b1;
    r_rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step_done", 64'(sd), 64'd0);
    chk("rst_frame_count", 64'(fc), 64'd0);
    chk("rst_rgb", 64'(rgb), 64'd0);
    chk("rst_state", 64'(st), 64'd0);
    chk("rst_pos", 64'(pos), 64'(INIT3));
    chk("rst_vel", 64'(vel), 64'd0);

    // timing of frame 1, with an extra frame_start during the update
    pulse_main();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("busy_k+%0d", c), 64'(busy), 64'(c <= 6));
      chk($sformatf("step_done_k+%0d", c), 64'(sd), 64'(c == 7));
      if (c == 3) fs = 1'b1;
      if (c == 4) fs = 1'b0;
      @(negedge clk);
    end
    chk("f1_frame_count", 64'(fc), 64'd1);
    chk("f1_pos", 64'(pos), 64'(INIT3));
    chk("f1_vel", 64'(vel), 64'({6'd1, 6'd1, 6'h3F, 6'h3F, 6'd0, 6'd0}));

    // frame 2
    run_frame(0, "f2_done");
    chk("f2_pos", 64'(pos),
        64'({10'd21, 10'd201, 10'd299, 10'd419, 10'd150, 10'd300}));
    chk("f2_vel", 64'(vel), 64'({6'd2, 6'd2, 6'h3E, 6'h3E, 6'd0, 6'd0}));
    chk("f2_frame_count", 64'(fc), 64'd2);

    // pause: three pulses ignored, rendering continues
    mode = 2'b10;
    px = 10'd300;
    py = 10'd150;
    va = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pulse_main();
      repeat (2) begin
        chk("pause_busy", 64'(busy), 64'd0);
        @(negedge clk);
      end
    end
    chk("pause_pos", 64'(pos),
        64'({10'd21, 10'd201, 10'd299, 10'd419, 10'd150, 10'd300}));
    chk("pause_frame_count", 64'(fc), 64'd2);
    chk("pause_rgb", 64'(rgb), 64'(C0));

    // asynchronous reset in the middle of ACCEL
    mode = 2'b00;
    pulse_main();
    chk("pre_rst_state", 64'(st), 64'd1);
    chk("pre_rst_rgb", 64'(rgb), 64'(C0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_rgb", 64'(rgb), 64'd0);
    chk("async_rst_pos", 64'(pos), 64'(INIT3));
    chk("async_rst_vel", 64'(vel), 64'd0);
    chk("async_rst_frame_count", 64'(fc), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    va = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 64'(st), 64'd0);

    // wrap: body0 x 638 + 3 -> 1
    w_mode = 2'b00;
    run_frame(1, "wrap_done");
    chk("wrap_x0", 64'(w_pos[9:0]), 64'd1);
    chk("wrap_y0", 64'(w_pos[19:10]), 64'd100);
    chk("wrap_vel", 64'(w_vel), 64'({6'd0, 6'd0, 6'd0, 6'd3}));
    chk("wrap_body1", 64'(w_pos[39:20]), 64'({10'd400, 10'd10}));

    // bounce: clamp at 639 and negate vx
    @(negedge clk) w_rst_n = 1'b0;
    @(negedge clk) w_rst_n = 1'b1;
    chk("bounce_rst_pos", 64'(w_pos), 64'({10'd400, 10'd10, 10'd100, 10'd638}));
    w_mode = 2'b01;
    run_frame(1, "bounce_done");
    chk("bounce_x0", 64'(w_pos[9:0]), 64'd639);
    chk("bounce_vx0", 64'(w_vel[5:0]), 64'h3D);
    chk("bounce_frame_count", 64'(w_fc), 64'd1);

    // render vectors: apply at negedge, compare after the following edge
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      r_px = tbl[t].x;
      r_py = tbl[t].y;
      r_va = tbl[t].v;
      @(posedge clk);
      #1;
      chk($sformatf("render_%0d", t), 64'(r_rgb), 64'(tbl[t].exp));
    end

    // exactly one clock of lag: miss, then hit held until the edge
    @(negedge clk);
    r_px = 10'd100;
    r_py = 10'd100;
    r_va = 1'b1;
    @(negedge clk);
    r_px = 10'd305;
    r_py = 10'd150;
    #1;
    chk("lag_before_edge", 64'(r_rgb), 64'd0);
    @(posedge clk);
    #1;
    chk("lag_after_edge", 64'(r_rgb), 64'(C0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
